// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: opcodes, FSM state encoding and the single-cycle result mux.
// The result function works on MAX_W-bit views, so DATA_WIDTH is limited to 64.
package seq_alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_LUI  = 4'd1;
    localparam logic [3:0] ALU_OR   = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_SRL  = 4'd4;
    localparam logic [3:0] ALU_SUB  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_XOR  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_MUL  = 4'd11;
    localparam logic [3:0] ALU_DIV  = 4'd12;
    localparam logic [3:0] ALU_DIVU = 4'd13;
    localparam logic [3:0] ALU_REM  = 4'd14;
    localparam logic [3:0] ALU_REMU = 4'd15;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Callers pass zero- and sign-extended views of each operand and truncate the return value.
    function automatic logic [MAX_W-1:0] alu_result(
        input logic [3:0]       op,
        input logic [MAX_W-1:0] a_u,
        input logic [MAX_W-1:0] b_u,
        input logic [MAX_W-1:0] a_s,
        input logic [MAX_W-1:0] b_s,
        input logic [5:0]       shamt
    );
        logic [MAX_W-1:0] r;
        r = '0;
        case (op)
            ALU_ADD:  r = a_u + b_u;
            ALU_LUI:  r = b_u << 12;
            ALU_OR:   r = a_u | b_u;
            ALU_SLL:  r = a_u << shamt;
            ALU_SRL:  r = a_u >> shamt;
            ALU_SUB:  r = a_u - b_u;
            ALU_AND:  r = a_u & b_u;
            ALU_XOR:  r = a_u ^ b_u;
            ALU_SRA:  r = $signed(a_s) >>> shamt;
            ALU_SLT:  r = {{(MAX_W-1){1'b0}}, ($signed(a_s) < $signed(b_s))};
            ALU_SLTU: r = {{(MAX_W-1){1'b0}}, (a_u < b_u)};
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/seq_muldiv_unit.sv
// Iterative multiply (shift-add) and restoring divide, one step per cycle for DATA_WIDTH cycles.
// done is high during the final step; result is the post-step value with sign fixup applied.
module seq_muldiv_unit
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [3:0]            op,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    logic [CNT_W-1:0]      count_q;
    logic                  is_mul_q, want_rem_q, neg_quo_q, neg_rem_q;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;   // product accumulator / partial remainder
    logic [DATA_WIDTH-1:0] sh_q, sh_d;     // multiplicand / dividend shifting into quotient
    logic [DATA_WIDTH-1:0] opb_q, opb_d;   // multiplier / divisor magnitude
    logic [DATA_WIDTH:0]   trial;
    logic                  op_signed, a_neg, b_neg;

    assign op_signed = (op == ALU_DIV) || (op == ALU_REM);
    assign a_neg     = op_signed && a[DATA_WIDTH-1];
    assign b_neg     = op_signed && b[DATA_WIDTH-1];

    // NOTE: every signal gets a default before the branches so no path infers a latch.
    always_comb begin : step
        acc_d = acc_q;
        sh_d  = sh_q;
        opb_d = opb_q;
        trial = '0;
        if (is_mul_q) begin
            if (opb_q[0]) acc_d = acc_q + sh_q;
            sh_d  = sh_q << 1;
            opb_d = opb_q >> 1;
        end else begin
            trial = {acc_q, sh_q[DATA_WIDTH-1]} - {1'b0, opb_q};
            if (!trial[DATA_WIDTH]) begin
                acc_d = trial[DATA_WIDTH-1:0];
                sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b1};
            end else begin
                acc_d = {acc_q[DATA_WIDTH-2:0], sh_q[DATA_WIDTH-1]};
                sh_d  = {sh_q[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_comb begin : fixup
        if (is_mul_q)        result = acc_d;
        else if (want_rem_q) result = neg_rem_q ? -acc_d : acc_d;
        else                 result = neg_quo_q ? -sh_d : sh_d;
    end

    assign done = (count_q == CNT_W'(1));

    // NOTE: datapath registers are reset as well, so a reset mid-operation leaves no stale state.
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            is_mul_q   <= 1'b0;
            want_rem_q <= 1'b0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            acc_q      <= '0;
            sh_q       <= '0;
            opb_q      <= '0;
        end else if (start) begin
            count_q    <= CNT_W'(DATA_WIDTH);
            is_mul_q   <= (op == ALU_MUL);
            want_rem_q <= (op == ALU_REM) || (op == ALU_REMU);
            neg_quo_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            acc_q      <= '0;
            sh_q       <= a_neg ? -a : a;
            opb_q      <= b_neg ? -b : b;
        end else if (count_q != '0) begin
            count_q <= count_q - CNT_W'(1);
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            opb_q   <= opb_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU with valid/ready handshake (IDLE -> [CALC] -> DONE -> IDLE).
// Define SEQ_ALU_MULDIV_EN to build the iterative mul/div datapath; otherwise ops 11-15 return 0.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  ready_o,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o
);
    state_t                state_q, state_d;
    logic                  load, needs_calc, mdu_done;
    logic [DATA_WIDTH-1:0] quick_result, result_d, mdu_result;

    always_comb begin : quick_path
        quick_result = DATA_WIDTH'(alu_result(ALU_Operation_i,
                                              MAX_W'(A_i), MAX_W'(B_i),
                                              MAX_W'($signed(A_i)), MAX_W'($signed(B_i)),
                                              6'(B_i[SHAMT_W-1:0])));
        needs_calc = 1'b0;
`ifdef SEQ_ALU_MULDIV_EN
        // Divide-by-zero and signed overflow resolve immediately instead of iterating.
        if (ALU_Operation_i == ALU_MUL) begin
            needs_calc = 1'b1;
        end else if (ALU_Operation_i inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU}) begin
            if (B_i == '0) begin
                quick_result = (ALU_Operation_i inside {ALU_DIV, ALU_DIVU}) ? '1 : A_i;
            end else if ((ALU_Operation_i inside {ALU_DIV, ALU_REM}) &&
                         (A_i == {1'b1, {(DATA_WIDTH-1){1'b0}}}) && (B_i == '1)) begin
                quick_result = (ALU_Operation_i == ALU_DIV) ? A_i : '0;
            end else begin
                needs_calc = 1'b1;
            end
        end
`endif
    end

`ifdef SEQ_ALU_MULDIV_EN
    logic mdu_start;
    assign mdu_start = (state_q == IDLE) && valid_i && needs_calc;

    seq_muldiv_unit #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .reset  (reset),
        .start  (mdu_start),
        .op     (ALU_Operation_i),
        .a      (A_i),
        .b      (B_i),
        .done   (mdu_done),
        .result (mdu_result)
    );
`else
    assign mdu_done   = 1'b0;
    assign mdu_result = '0;
`endif

    always_comb begin : fsm_next
        state_d  = state_q;
        load     = 1'b0;
        result_d = ALU_Result_o;
        ready_o  = (state_q == IDLE);
        valid_o  = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    if (needs_calc) begin
                        state_d = CALC;
                    end else begin
                        state_d  = DONE;
                        load     = 1'b1;
                        result_d = quick_result;
                    end
                end
            end
            CALC: begin
                if (mdu_done) begin
                    state_d  = DONE;
                    load     = 1'b1;
                    result_d = mdu_result;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result and Zero only change on entry to DONE, so intermediate CALC values never leak out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ALU_Result_o <= '0;
            Zero_o       <= 1'b1;
        end else begin
            state_q <= state_d;
            if (load) begin
                ALU_Result_o <= result_d;
                Zero_o       <= (result_d == '0);
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed scenarios plus random ops against an arithmetic reference model.
module tb_seq_alu;

`ifdef SEQ_ALU_MULDIV_EN
    localparam bit MULDIV_EN = 1'b1;
`else
    localparam bit MULDIV_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic [3:0]  ALU_Operation_i;
    logic [31:0] A_i;
    logic [31:0] B_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] ALU_Result_o;
    logic        Zero_o;

    int n_pass   = 0;
    int n_checks = 0;

    seq_alu dut (
        .clk             (clk),
        .reset           (reset),
        .valid_i         (valid_i),
        .ALU_Operation_i (ALU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .ready_o         (ready_o),
        .valid_o         (valid_o),
        .ALU_Result_o    (ALU_Result_o),
        .Zero_o          (Zero_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    function automatic bit is_div_special(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op < 4'd12) return 1'b0;
        if (b == 32'd0) return 1'b1;
        return ((op == 4'd12) || (op == 4'd14)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    endfunction

    // Reference result computed from the opcode definitions with plain integer arithmetic.
    function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        int unsigned sh;
        longint      la, lb;
        sa = int'(a);
        sb = int'(b);
        sh = {27'd0, b[4:0]};
        la = longint'(sa);
        lb = longint'(sb);
        case (op)
            4'd0:  return a + b;
            4'd1:  return b << 12;
            4'd2:  return a | b;
            4'd3:  return a << sh;
            4'd4:  return a >> sh;
            4'd5:  return a - b;
            4'd6:  return a & b;
            4'd7:  return a ^ b;
            4'd8:  return 32'(sa >>> sh);
            4'd9:  return {31'd0, (sa < sb)};
            4'd10: return {31'd0, (a < b)};
            default: begin
                if (!MULDIV_EN) return 32'd0;
                case (op)
                    4'd11:   return 32'(la * lb);
                    4'd12:   return (b == 0) ? 32'hFFFF_FFFF : 32'(la / lb);
                    4'd13:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
                    4'd14:   return (b == 0) ? a : 32'(la % lb);
                    default: return (b == 0) ? a : a % b;
                endcase
            end
        endcase
    endfunction

    function automatic int model_latency(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!MULDIV_EN || op < 4'd11 || is_div_special(op, a, b)) return 1;
        return 33;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp_res;
        int          exp_lat, lat, ready_busy;
        bit          seen;
        exp_res    = model_result(op, a, b);
        exp_lat    = model_latency(op, a, b);
        lat        = 0;
        ready_busy = 0;
        seen       = 1'b0;
        check({tag, ".idle"}, 32'(ready_o), 32'd1);
        valid_i         = 1'b1;
        ALU_Operation_i = op;
        A_i             = a;
        B_i             = b;
        @(posedge clk);
        #1;
        valid_i         = 1'b0;
        ALU_Operation_i = 4'($urandom);
        A_i             = $urandom;
        B_i             = $urandom;
        for (int c = 1; c <= 100 && !seen; c++) begin
            @(negedge clk);
            if (valid_o) begin
                seen = 1'b1;
                lat  = c;
            end else if (ready_o) begin
                ready_busy++;
            end
        end
        check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check({tag, ".res"}, ALU_Result_o, exp_res);
        check({tag, ".zero"}, 32'(Zero_o), 32'(exp_res == 32'd0));
        check({tag, ".busy_ready"}, 32'(ready_busy), 32'd0);
        @(negedge clk);
        check({tag, ".pulse"}, 32'(valid_o), 32'd0);
        check({tag, ".hold"}, ALU_Result_o, exp_res);
    endtask

    initial begin
        int          pulses;
        logic [3:0]  op;
        logic [31:0] a, b;

        reset           = 1'b1;
        valid_i         = 1'b0;
        ALU_Operation_i = 4'd0;
        A_i             = 32'd0;
        B_i             = 32'd0;
        #1;
        check("rst.ready", 32'(ready_o), 32'd1);
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.result", ALU_Result_o, 32'd0);
        check("rst.zero", 32'(Zero_o), 32'd1);
        @(negedge clk);
        reset = 1'b0;

        // Reset in the middle of a divide aborts it.
        @(negedge clk);
        valid_i         = 1'b1;
        ALU_Operation_i = 4'd12;
        A_i             = 32'd100;
        B_i             = 32'd7;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        pulses  = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (valid_o) pulses++;
        end
        reset = 1'b1;
        #1;
        check("abort.ready", 32'(ready_o), 32'd1);
        check("abort.valid", 32'(valid_o), 32'd0);
        check("abort.result", ALU_Result_o, 32'd0);
        check("abort.zero", 32'(Zero_o), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (valid_o) pulses++;
        end
        check("abort.pulses", 32'(pulses), MULDIV_EN ? 32'd0 : 32'd1);
        check("abort.result_after", ALU_Result_o, 32'd0);

        // Directed scenarios.
        run_op(4'd5,  32'd5,              32'd5,              "sub_zero");
        run_op(4'd8,  32'h8000_0000,      32'h0000_0024,      "sra");
        run_op(4'd11, 32'hFFFF_FFFD,      32'd7,              "mul_neg");
        run_op(4'd12, 32'hFFFF_FFEC,      32'd3,              "div_neg");
        run_op(4'd14, 32'hFFFF_FFEC,      32'd3,              "rem_neg");
        run_op(4'd13, 32'd7,              32'd0,              "divu_zero");
        run_op(4'd14, 32'd9,              32'd0,              "rem_zero");
        run_op(4'd12, 32'h8000_0000,      32'hFFFF_FFFF,      "div_ovf");
        run_op(4'd14, 32'h8000_0000,      32'hFFFF_FFFF,      "rem_ovf");
        run_op(4'd15, 32'hFFFF_FFFF,      32'd10,             "remu");
        run_op(4'd1,  32'd0,              32'h000A_BCDE,      "lui");
        run_op(4'd9,  32'hFFFF_FFFF,      32'd1,              "slt");

        // valid_i held high across the DONE cycle: second request taken two cycles later, once.
        valid_i         = 1'b1;
        ALU_Operation_i = 4'd0;
        A_i             = 32'd5;
        B_i             = 32'hFFFF_FFFB;
        @(posedge clk);
        #1;
        ALU_Operation_i = 4'd10;
        A_i             = 32'd1;
        B_i             = 32'hFFFF_FFFF;
        @(negedge clk);
        check("b2b.first_valid", 32'(valid_o), 32'd1);
        check("b2b.first_res", ALU_Result_o, 32'd0);
        check("b2b.first_zero", 32'(Zero_o), 32'd1);
        @(negedge clk);
        check("b2b.gap_valid", 32'(valid_o), 32'd0);
        check("b2b.gap_ready", 32'(ready_o), 32'd1);
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        check("b2b.second_valid", 32'(valid_o), 32'd1);
        check("b2b.second_res", ALU_Result_o, 32'd1);
        check("b2b.second_zero", 32'(Zero_o), 32'd0);
        pulses = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (valid_o) pulses++;
        end
        check("b2b.no_reissue", 32'(pulses), 32'd0);

        // Random operations, biased toward the divide corner cases.
        for (int i = 0; i < 60; i++) begin
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                2: a = 32'h8000_0000;
                3: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                4: b = 32'($urandom_range(1, 9));
                default: ;
            endcase
            run_op(op, a, b, $sformatf("rand%0d_op%0d", i, op));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
